fifo_wr_arbiter: RTL and testbench

Round-robin arbiter that shares the write port of the team's synchronous 8-bit FIFO (syn_fifo) among N_REQ producers.
- Each producer uses a valid/ready handshake.
- The arbiter drives the FIFO write_en/data_in and back-pressures on full.
- A granted producer keeps the port for a burst of up to BURST beats, then the grant rotates.
- Sits directly in front of syn_fifo.

---
 rtl/fifo_wr_arbiter_pkg.sv | 18 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 28 ++
 rtl/fifo_wr_arbiter.sv | 120 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter and its round-robin picker.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   // Index widths are clamped to one bit so a degenerate count still yields a legal vector.
   function automatic int grant_width(input int n_req);
      return (n_req > 1) ? $clog2(n_req) : 1;
   endfunction

   function automatic int beat_width(input int burst);
      return (burst > 1) ? $clog2(burst) : 1;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request at or above ptr, wrapping.
module rr_pick #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic         found,
   output logic [W-1:0] index
);

   logic [W-1:0] cand;

   // Walk offsets from farthest to nearest so the nearest set bit is the last one written.
   always_comb begin
      found = 1'b0;
      index = '0;
      cand  = '0;
      for (int i = N - 1; i >= 0; i--) begin
         cand = W'((int'(ptr) + i) % N);
         if (req[cand]) begin
            found = 1'b1;
            index = cand;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the syn_fifo write port among N_REQ valid/ready producers.
// Optional FIFO_WR_ARBITER_PRIO0_EN makes requester 0 high priority with preemption.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 8,
   parameter int BURST  = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [N_REQ-1:0]              req_valid,
   input  logic [N_REQ*DATA_W-1:0]       req_data,
   output logic [N_REQ-1:0]              req_ready,
   input  logic                          fifo_full,
   output logic                          fifo_write_en,
   output logic [DATA_W-1:0]             fifo_data_in,
   output logic [grant_width(N_REQ)-1:0] grant_id,
   output logic                          busy
);

   localparam int GW = grant_width(N_REQ);
   localparam int BW = beat_width(BURST);
   localparam logic [GW-1:0] LAST_ID   = GW'(N_REQ - 1);
   localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);

   arb_state_e    state_q, state_d;
   logic [GW-1:0] grant_id_q, grant_id_d;
   logic [GW-1:0] rr_ptr_q, rr_ptr_d;
   logic [BW-1:0] beat_cnt_q, beat_cnt_d;

   logic          pick_found;
   logic [GW-1:0] pick_idx;
   logic          grant_valid;
   logic          beat_acc;
   logic          last_beat;

   rr_pick #(
      .N (N_REQ),
      .W (GW)
   ) u_rr_pick (
      .req   (req_valid),
      .ptr   (rr_ptr_q),
      .found (pick_found),
      .index (pick_idx)
   );

   always_comb begin
      req_ready    = '0;
      fifo_data_in = '0;
      grant_valid  = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_id_q == GW'(i)) begin
            grant_valid = req_valid[i];
            if (state_q == GRANT) begin
               req_ready[i] = !fifo_full;
               fifo_data_in = req_data[i*DATA_W +: DATA_W];
            end
         end
      end
      beat_acc  = (state_q == GRANT) && grant_valid && !fifo_full;
      last_beat = beat_acc && (beat_cnt_q == LAST_BEAT);
   end

   assign fifo_write_en = beat_acc;
   assign busy          = (state_q == GRANT);
   assign grant_id      = grant_id_q;

   // A dropped valid releases even under back-pressure; that partial burst still advances rr_ptr.
   always_comb begin
      state_d    = state_q;
      grant_id_d = grant_id_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      if (state_q == IDLE) begin
`ifdef FIFO_WR_ARBITER_PRIO0_EN
         if (req_valid[0]) begin
            state_d    = GRANT;
            grant_id_d = '0;
            beat_cnt_d = '0;
         end else
`endif
         if (pick_found) begin
            state_d    = GRANT;
            grant_id_d = pick_idx;
            beat_cnt_d = '0;
         end
      end else begin
         if (beat_acc) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
         end
         if (!grant_valid || last_beat) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
            rr_ptr_d   = (grant_id_q == LAST_ID) ? '0 : grant_id_q + 1'b1;
         end
`ifdef FIFO_WR_ARBITER_PRIO0_EN
         else if ((grant_id_q != '0) && req_valid[0] && beat_acc) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         grant_id_q <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_id_q <= grant_id_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Table-driven cycle-by-cycle bench for fifo_wr_arbiter (N_REQ=4, DATA_W=8, BURST=4).
// Prio-mode expectations are selected by FIFO_WR_ARBITER_PRIO0_EN.
module tb_fifo_wr_arbiter;

   logic        clk;
   logic        reset;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        fifo_full;
   logic        fifo_write_en;
   logic [7:0]  fifo_data_in;
   logic [1:0]  grant_id;
   logic        busy;

   typedef struct {
      string       name;
      logic        rst;
      logic [3:0]  valid;
      logic [31:0] data;
      logic        full;
      logic [3:0]  ready;
      logic        we;
      logic [7:0]  din;
      logic [1:0]  gid;
      logic        busy;
      int          seg;
   } vec_t;

   vec_t vecs[$];

   int checks    = 0;
   int errors    = 0;
   int rr_writes = 0;
   int bp_writes = 0;

   localparam logic [31:0] D_ALL = 32'hD3C2_B1A0;
   localparam logic [31:0] D_A1  = 32'h00A1_0000;
   localparam logic [31:0] D_A2  = 32'h00A2_0000;

   fifo_wr_arbiter #(
      .N_REQ  (4),
      .DATA_W (8),
      .BURST  (4)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_ready     (req_ready),
      .fifo_full     (fifo_full),
      .fifo_write_en (fifo_write_en),
      .fifo_data_in  (fifo_data_in),
      .grant_id      (grant_id),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic addVec(input string n, input logic r, input logic [3:0] v, input logic [31:0] d,
                         input logic f, input logic [3:0] rdy, input logic we, input logic [7:0] din,
                         input logic [1:0] gid, input logic b, input int seg);
      vec_t e;
      e.name  = n;
      e.rst   = r;
      e.valid = v;
      e.data  = d;
      e.full  = f;
      e.ready = rdy;
      e.we    = we;
      e.din   = din;
      e.gid   = gid;
      e.busy  = b;
      e.seg   = seg;
      vecs.push_back(e);
   endtask

   // Inputs change on the falling edge; outputs are sampled 1ns later, well clear of the rising edge.
   task automatic applyStimulus(input vec_t e);
      @(negedge clk);
      reset     = e.rst;
      req_valid = e.valid;
      req_data  = e.data;
      fifo_full = e.full;
      #1;
   endtask

   task automatic checkOutput(input vec_t e);
      checks++;
      if ({req_ready, fifo_write_en, fifo_data_in, grant_id, busy} !==
          {e.ready, e.we, e.din, e.gid, e.busy}) begin
         errors++;
         $display("[TB] FAIL %s: got ready=%b we=%b data=%h gid=%0d busy=%b, expected ready=%b we=%b data=%h gid=%0d busy=%b",
                  e.name, req_ready, fifo_write_en, fifo_data_in, grant_id, busy,
                  e.ready, e.we, e.din, e.gid, e.busy);
      end
   endtask

   task automatic checkCount(input string n, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", n, got, exp);
      end
   endtask

   initial begin
      reset     = 1'b0;
      req_valid = '0;
      req_data  = '0;
      fifo_full = 1'b0;

      // Reset held with every requester asking, then the first grant goes to requester 0.
      addVec("rst_hold0",  0, 4'hF, D_ALL, 0, 4'b0000, 0, 8'h00, 0, 0, 0);
      addVec("rst_hold1",  0, 4'hF, D_ALL, 0, 4'b0000, 0, 8'h00, 0, 0, 0);
      addVec("idle_first", 1, 4'hF, D_ALL, 0, 4'b0000, 0, 8'h00, 0, 0, 0);

`ifndef FIFO_WR_ARBITER_PRIO0_EN
      // Full rotation 0,1,2,3 with one idle cycle between grants: 16 writes in 20 cycles.
      for (int i = 0; i < 4; i++) addVec("rr_g0", 1, 4'hF, D_ALL, 0, 4'b0001, 1, 8'hA0, 0, 1, 1);
      addVec("rr_idle0", 1, 4'hF, D_ALL, 0, 4'b0000, 0, 8'h00, 0, 0, 1);
      for (int i = 0; i < 4; i++) addVec("rr_g1", 1, 4'hF, D_ALL, 0, 4'b0010, 1, 8'hB1, 1, 1, 1);
      addVec("rr_idle1", 1, 4'hF, D_ALL, 0, 4'b0000, 0, 8'h00, 1, 0, 1);
      for (int i = 0; i < 4; i++) addVec("rr_g2", 1, 4'hF, D_ALL, 0, 4'b0100, 1, 8'hC2, 2, 1, 1);
      addVec("rr_idle2", 1, 4'hF, D_ALL, 0, 4'b0000, 0, 8'h00, 2, 0, 1);
      for (int i = 0; i < 4; i++) addVec("rr_g3", 1, 4'hF, D_ALL, 0, 4'b1000, 1, 8'hD3, 3, 1, 1);
      addVec("rr_idle3", 1, 4'hF, D_ALL, 0, 4'b0000, 0, 8'h00, 3, 0, 1);
      addVec("rr_wrap_g0", 1, 4'hF, D_ALL, 0, 4'b0001, 1, 8'hA0, 0, 1, 0);
      addVec("rr_drop",    1, 4'h0, D_ALL, 0, 4'b0001, 0, 8'hA0, 0, 1, 0);
      addVec("rr_quiet",   1, 4'h0, D_ALL, 0, 4'b0000, 0, 8'h00, 0, 0, 0);

      // Requester 2 sends A1, A2 then drops valid; the next search starts at 3.
      addVec("er_idle",    1, 4'b0100, D_A1,  0, 4'b0000, 0, 8'h00, 0, 0, 0);
      addVec("er_beat_a1", 1, 4'b0100, D_A1,  0, 4'b0100, 1, 8'hA1, 2, 1, 0);
      addVec("er_beat_a2", 1, 4'b0100, D_A2,  0, 4'b0100, 1, 8'hA2, 2, 1, 0);
      addVec("er_drop",    1, 4'b0000, D_A2,  0, 4'b0100, 0, 8'hA2, 2, 1, 0);
      addVec("er_idle2",   1, 4'hF,    D_ALL, 0, 4'b0000, 0, 8'h00, 2, 0, 0);
      addVec("er_next_g3", 1, 4'hF,    D_ALL, 0, 4'b1000, 1, 8'hD3, 3, 1, 0);
      addVec("er_g3_drop", 1, 4'h0,    D_ALL, 0, 4'b1000, 0, 8'hD3, 3, 1, 0);

      // Requester 1 stalled by fifo_full for 5 cycles mid-burst; burst still totals 4 beats.
      addVec("bp_idle",  1, 4'b0010, D_ALL, 0, 4'b0000, 0, 8'h00, 3, 0, 0);
      addVec("bp_beat0", 1, 4'b0010, D_ALL, 0, 4'b0010, 1, 8'hB1, 1, 1, 2);
      addVec("bp_beat1", 1, 4'b0010, D_ALL, 0, 4'b0010, 1, 8'hB1, 1, 1, 2);
      for (int i = 0; i < 5; i++) addVec("bp_full", 1, 4'b0010, D_ALL, 1, 4'b0000, 0, 8'hB1, 1, 1, 2);
      addVec("bp_beat2",    1, 4'b0010, D_ALL, 0, 4'b0010, 1, 8'hB1, 1, 1, 2);
      addVec("bp_beat3",    1, 4'b0010, D_ALL, 0, 4'b0010, 1, 8'hB1, 1, 1, 2);
      addVec("bp_released", 1, 4'b0000, D_ALL, 0, 4'b0000, 0, 8'h00, 1, 0, 2);

      // Reset lands after beat 2 of requester 3; outputs clear before any clock edge.
      addVec("mr_idle",       1, 4'b1000, D_ALL, 0, 4'b0000, 0, 8'h00, 1, 0, 0);
      addVec("mr_beat0",      1, 4'b1000, D_ALL, 0, 4'b1000, 1, 8'hD3, 3, 1, 0);
      addVec("mr_beat1",      1, 4'b1000, D_ALL, 0, 4'b1000, 1, 8'hD3, 3, 1, 0);
      addVec("mr_reset0",     0, 4'b1000, D_ALL, 0, 4'b0000, 0, 8'h00, 0, 0, 0);
      addVec("mr_reset1",     0, 4'b1000, D_ALL, 0, 4'b0000, 0, 8'h00, 0, 0, 0);
      addVec("mr_idle_after", 1, 4'hF,    D_ALL, 0, 4'b0000, 0, 8'h00, 0, 0, 0);
      addVec("mr_regrant0",   1, 4'hF,    D_ALL, 0, 4'b0001, 1, 8'hA0, 0, 1, 0);
`endif
      addVec("pre_drop",  1, 4'h0, D_ALL, 0, 4'b0001, 0, 8'hA0, 0, 1, 0);
      addVec("pre_quiet", 1, 4'h0, D_ALL, 0, 4'b0000, 0, 8'h00, 0, 0, 0);

      // Requester 2 bursting when requester 0 raises valid.
      addVec("pr_idle",  1, 4'b0100, D_ALL, 0, 4'b0000, 0, 8'h00, 0, 0, 0);
      addVec("pr_beat0", 1, 4'b0100, D_ALL, 0, 4'b0100, 1, 8'hC2, 2, 1, 0);
      addVec("pr_req0",  1, 4'b0101, D_ALL, 0, 4'b0100, 1, 8'hC2, 2, 1, 0);
`ifdef FIFO_WR_ARBITER_PRIO0_EN
      addVec("pr_preempt_idle", 1, 4'b0101, D_ALL, 0, 4'b0000, 0, 8'h00, 2, 0, 0);
      addVec("pr_g0",           1, 4'b0101, D_ALL, 0, 4'b0001, 1, 8'hA0, 0, 1, 0);
`else
      addVec("pr_beat2", 1, 4'b0101, D_ALL, 0, 4'b0100, 1, 8'hC2, 2, 1, 0);
      addVec("pr_beat3", 1, 4'b0101, D_ALL, 0, 4'b0100, 1, 8'hC2, 2, 1, 0);
      addVec("pr_idle2", 1, 4'b0101, D_ALL, 0, 4'b0000, 0, 8'h00, 2, 0, 0);
      addVec("pr_g0",    1, 4'b0101, D_ALL, 0, 4'b0001, 1, 8'hA0, 0, 1, 0);
`endif

      for (int k = 0; k < vecs.size(); k++) begin
         applyStimulus(vecs[k]);
         checkOutput(vecs[k]);
         if (vecs[k].seg == 1 && fifo_write_en) rr_writes++;
         if (vecs[k].seg == 2 && fifo_write_en) bp_writes++;
      end

`ifndef FIFO_WR_ARBITER_PRIO0_EN
      checkCount("rr_write_total", rr_writes, 16);
      checkCount("bp_write_total", bp_writes, 4);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
